// File: rtl/dma_priority_resolver.sv
// DMA request/priority stage: DREQ qualification, fixed/rotating arbitration and HRQ/HLDA handshake.
// Optional DMA_SWREQ_EN adds a software request input that bypasses mask and sense.
module dma_priority_resolver #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CH_W   = 2
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic [NUM_CH-1:0] DREQ,
  input  logic [NUM_CH-1:0] maskReg,
`ifdef DMA_SWREQ_EN
  input  logic [NUM_CH-1:0] swReq,
`endif
  input  logic              priorityType,
  input  logic              dreqSenseLow,
  input  logic              controllerDisable,
  input  logic              HLDA,
  input  logic              cycleDone,
  output logic              HRQ,
  output logic [NUM_CH-1:0] DACK,
  output logic              grantValid,
  output logic [CH_W-1:0]   activeChannel
);

  typedef enum logic [3:0] {
    StIdle    = 4'b0001,
    StReq     = 4'b0010,
    StGrant   = 4'b0100,
    StRelease = 4'b1000
  } state_e;

  localparam logic [NUM_CH-1:0] OneLsb = {{(NUM_CH-1){1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic              hrq_q, hrq_d;
  logic [NUM_CH-1:0] dack_q, dack_d;
  logic              gv_q, gv_d;
  logic [CH_W-1:0]   act_q, act_d;
  logic [CH_W-1:0]   prio_q, prio_d;

  logic [NUM_CH-1:0] req;
  logic [CH_W-1:0]   winner;
  logic              found;
  int unsigned       idx;

`ifdef DMA_SWREQ_EN
  assign req = ((DREQ ^ {NUM_CH{dreqSenseLow}}) & ~maskReg) | swReq;
`else
  assign req = (DREQ ^ {NUM_CH{dreqSenseLow}}) & ~maskReg;
`endif

  // Scan starts at ch0 (fixed) or at the rotating pointer; first active request wins.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      idx = priorityType ? (32'(prio_q) + i) % NUM_CH : i;
      if (!found && req[idx[CH_W-1:0]]) begin
        winner = CH_W'(idx);
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    hrq_d   = hrq_q;
    dack_d  = dack_q;
    gv_d    = gv_q;
    act_d   = act_q;
    prio_d  = prio_q;
    unique case (state_q)
      StIdle: begin
        if (|req && !controllerDisable) begin
          state_d = StReq;
          hrq_d   = 1'b1;
        end
      end
      StReq: begin
        if (!(|req)) begin
          state_d = StIdle;
          hrq_d   = 1'b0;
        end else if (HLDA) begin
          state_d = StGrant;
          dack_d  = OneLsb << winner;
          gv_d    = 1'b1;
          act_d   = winner;
        end
      end
      StGrant: begin
        // Grant is frozen until tC signals the end of service.
        if (cycleDone) begin
          state_d = StRelease;
          hrq_d   = 1'b0;
          dack_d  = '0;
          gv_d    = 1'b0;
          if (priorityType) begin
            prio_d = CH_W'((32'(act_q) + 1) % NUM_CH);
          end
        end
      end
      StRelease: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        hrq_d   = 1'b0;
        dack_d  = '0;
        gv_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= StIdle;
      hrq_q   <= 1'b0;
      dack_q  <= '0;
      gv_q    <= 1'b0;
      act_q   <= '0;
      prio_q  <= '0;
    end else begin
      state_q <= state_d;
      hrq_q   <= hrq_d;
      dack_q  <= dack_d;
      gv_q    <= gv_d;
      act_q   <= act_d;
      prio_q  <= prio_d;
    end
  end

  assign HRQ           = hrq_q;
  assign DACK          = dack_q;
  assign grantValid    = gv_q;
  assign activeChannel = act_q;

endmodule

// File: tb/tb_dma_priority_resolver.sv
// Bench for dma_priority_resolver: directed scenarios then randomized traffic against a flag-based model.
// Define DMA_SWREQ_EN for both files to exercise the software request input.
module tb_dma_priority_resolver;
  localparam int N = 4;

  logic         CLK = 1'b0;
  logic         RESET_N = 1'b0;
  logic [N-1:0] DREQ = '0;
  logic [N-1:0] maskReg = '0;
  logic [N-1:0] swReq = '0;
  logic         priorityType = 1'b0;
  logic         dreqSenseLow = 1'b0;
  logic         controllerDisable = 1'b0;
  logic         HLDA = 1'b0;
  logic         cycleDone = 1'b0;
  logic         HRQ;
  logic [N-1:0] DACK;
  logic         grantValid;
  logic [1:0]   activeChannel;

  int checks = 0;
  int errors = 0;

  // Model: m_ch = granted channel (-1 none), m_hrq = hold requested, m_cool = release cycle.
  int m_ch, m_prio, m_last;
  bit m_hrq, m_cool;

  logic [N-1:0] exp_seq [5];

  always #5 CLK = ~CLK;

  dma_priority_resolver #(
    .NUM_CH(N),
    .CH_W  (2)
  ) dut (
    .CLK              (CLK),
    .RESET_N          (RESET_N),
    .DREQ             (DREQ),
    .maskReg          (maskReg),
`ifdef DMA_SWREQ_EN
    .swReq            (swReq),
`endif
    .priorityType     (priorityType),
    .dreqSenseLow     (dreqSenseLow),
    .controllerDisable(controllerDisable),
    .HLDA             (HLDA),
    .cycleDone        (cycleDone),
    .HRQ              (HRQ),
    .DACK             (DACK),
    .grantValid       (grantValid),
    .activeChannel    (activeChannel)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] model_req();
    logic [N-1:0] r;
    r = ((DREQ ^ {N{dreqSenseLow}}) & ~maskReg);
`ifdef DMA_SWREQ_EN
    r = r | swReq;
`endif
    return r;
  endfunction

  // Winner = active request with the smallest distance from the highest-priority channel.
  function automatic int model_winner(input logic [N-1:0] r, input bit rot, input int p);
    int best, bestd, d;
    best  = -1;
    bestd = N;
    for (int i = 0; i < N; i++) begin
      if (r[i]) begin
        d = rot ? (i - p + N) % N : i;
        if (d < bestd) begin
          bestd = d;
          best  = i;
        end
      end
    end
    return best;
  endfunction

  task automatic model_reset();
    m_ch   = -1;
    m_prio = 0;
    m_last = 0;
    m_hrq  = 1'b0;
    m_cool = 1'b0;
  endtask

  task automatic model_step();
    logic [N-1:0] r;
    r = model_req();
    if (m_cool) begin
      m_cool = 1'b0;
    end else if (m_ch >= 0) begin
      if (cycleDone) begin
        if (priorityType) m_prio = (m_ch + 1) % N;
        m_ch   = -1;
        m_hrq  = 1'b0;
        m_cool = 1'b1;
      end
    end else if (m_hrq) begin
      if (r == '0) m_hrq = 1'b0;
      else if (HLDA) begin
        m_ch   = model_winner(r, priorityType, m_prio);
        m_last = m_ch;
      end
    end else if (r != '0 && !controllerDisable) begin
      m_hrq = 1'b1;
    end
  endtask

  task automatic check_all();
    logic [N-1:0] edack;
    edack = (m_ch >= 0) ? N'(1 << m_ch) : '0;
    chk("hrq", 32'(HRQ), 32'(m_hrq));
    chk("dack", 32'(DACK), 32'(edack));
    chk("grant_valid", 32'(grantValid), 32'(m_ch >= 0));
    chk("active_channel", 32'(activeChannel), 32'(m_last));
    chk("dack_onehot0", 32'($onehot0(DACK)), 32'd1);
    chk("gv_vs_dack", 32'(grantValid), 32'(|DACK));
  endtask

  task automatic tick();
    @(posedge CLK);
    model_step();
    @(negedge CLK);
    check_all();
  endtask

  task automatic finish_grant();
    cycleDone = 1'b1;
    tick();
    cycleDone = 1'b0;
    tick();
  endtask

  initial begin
    exp_seq[0] = 4'b0001;
    exp_seq[1] = 4'b0010;
    exp_seq[2] = 4'b0100;
    exp_seq[3] = 4'b1000;
    exp_seq[4] = 4'b0001;

    model_reset();
    #12;
    check_all();
    @(negedge CLK);
    RESET_N = 1'b1;

    // Fixed priority, DREQ=0111: HRQ after one clock, DACK after two.
    DREQ = 4'b0111;
    HLDA = 1'b1;
    tick();
    chk("fixed_hrq_p1", 32'(HRQ), 32'd1);
    chk("fixed_nodack_p1", 32'(DACK), 32'd0);
    tick();
    chk("fixed_dack_p2", 32'(DACK), 32'b0001);
    repeat (3) begin
      DREQ = 4'(~DREQ);
      tick();
      chk("fixed_active_hold", 32'(activeChannel), 32'd0);
    end
    finish_grant();
    chk("fixed_released", 32'(grantValid), 32'd0);

    // Rotating priority with all channels requesting: 0,1,2,3 then wrap to 0.
    priorityType = 1'b1;
    DREQ = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      tick();
      chk("rot_dack", 32'(DACK), 32'(exp_seq[k]));
      finish_grant();
    end

    // Masking and active-low sense.
    priorityType = 1'b0;
    maskReg = 4'b0001;
    DREQ = 4'b0011;
    tick();
    tick();
    chk("mask_dack", 32'(DACK), 32'b0010);
    finish_grant();
    maskReg = 4'b0000;
    dreqSenseLow = 1'b1;
    DREQ = 4'b1110;
    tick();
    tick();
    chk("sense_low_dack", 32'(DACK), 32'b0001);
    finish_grant();

    // HLDA withheld, then request withdrawn: HRQ drops, no DACK.
    dreqSenseLow = 1'b0;
    DREQ = 4'b0001;
    HLDA = 1'b0;
    tick();
    chk("nohlda_hrq_up", 32'(HRQ), 32'd1);
    repeat (4) begin
      tick();
      chk("nohlda_hrq_held", 32'(HRQ), 32'd1);
      chk("nohlda_no_dack", 32'(DACK), 32'd0);
    end
    DREQ = 4'b0000;
    tick();
    chk("nohlda_hrq_drop", 32'(HRQ), 32'd0);
    tick();
    chk("nohlda_still_no_dack", 32'(DACK), 32'd0);

    // Asynchronous reset in the middle of a grant.
    HLDA = 1'b1;
    DREQ = 4'b0100;
    tick();
    tick();
    chk("rst_pre_dack", 32'(DACK), 32'b0100);
    tick();
    RESET_N = 1'b0;
    #1;
    chk("rst_async_dack", 32'(DACK), 32'd0);
    chk("rst_async_hrq", 32'(HRQ), 32'd0);
    chk("rst_async_gv", 32'(grantValid), 32'd0);
    model_reset();
    DREQ = 4'b0000;
    @(negedge CLK);
    RESET_N = 1'b1;
    tick();
    chk("rst_idle_hrq", 32'(HRQ), 32'd0);

`ifdef DMA_SWREQ_EN
    // Software request overrides a full mask.
    maskReg = 4'b1111;
    swReq = 4'b1000;
    tick();
    tick();
    chk("swreq_dack", 32'(DACK), 32'b1000);
    finish_grant();
    swReq = 4'b0000;
    maskReg = 4'b0000;
`endif

    // Randomized traffic.
    repeat (600) begin
      DREQ = N'($urandom);
      maskReg = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      if ($urandom_range(0, 19) == 0) priorityType = ~priorityType;
      if ($urandom_range(0, 29) == 0) dreqSenseLow = ~dreqSenseLow;
      controllerDisable = ($urandom_range(0, 9) == 0);
      HLDA = ($urandom_range(0, 3) != 0);
      cycleDone = ($urandom_range(0, 3) == 0);
`ifdef DMA_SWREQ_EN
      swReq = ($urandom_range(0, 4) == 0) ? N'($urandom) : '0;
`endif
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
